afu_write_stage: RTL and testbench

Downstream neighbour of the transpose AFU user block. Drains its 512-bit output FIFO and turns each popped cacheline into a memory write request at a sequential destination address. Enforces an outstanding-write credit limit and raises done once ctx_length write completions have returned. Sits between the AFU output FIFO and the host write channel.

---
 rtl/afu_pkg.sv | 15 +
 rtl/wr_skid_buffer.sv | 50 +++++
 rtl/afu_write_stage.sv | 127 ++++++++++++
 tb/tb_afu_write_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afu_pkg.sv
// Shared types and constants for the AFU write path.
package afu_pkg;

  localparam int CL_WIDTH      = 512;
  localparam int CNT_WIDTH_DEF = 32;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } afu_state_e;

endpackage

// File: rtl/wr_skid_buffer.sv
// Two-entry cacheline FIFO between the output-FIFO read port and the write channel.
module wr_skid_buffer
  import afu_pkg::*;
#(
  parameter int W = CL_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign push_ok   = push && ((count != 2'd2) || pop);
  assign pop_ok    = pop && (count != 2'd0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/afu_write_stage.sv
// Drains the AFU output FIFO into sequential cacheline writes under an outstanding-credit limit.
//   state   | meaning
//   IDLE    | waiting for start after reset
//   RUN     | popping, issuing and counting completions
//   DONE    | all ctx_length completions returned; waits for next start
module afu_write_stage
  import afu_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  ctx_length,
  input  logic [ADDR_WIDTH-1:0] dst_base_addr,
  input  logic [CL_WIDTH-1:0]   fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [CL_WIDTH-1:0]   wr_req_data,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  rsp_error
);

  afu_state_e            state;
  logic [CNT_WIDTH-1:0]  len;
  logic [CNT_WIDTH-1:0]  pop_cnt;
  logic [CNT_WIDTH-1:0]  issue_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt;
  logic [CNT_WIDTH-1:0]  rsp_cnt_nxt;
  logic [ADDR_WIDTH-1:0] base_addr;
  cnt_t                  outstanding;
  cnt_t                  in_flight;
  logic                  pop_pending;
  logic [1:0]            buf_cnt;
  logic                  issue;
  logic                  rsp_ok;
  logic                  rsp_bad;
  logic                  start_ok;
  logic                  buf_room;

  assign issue    = wr_req_valid && wr_req_ready;
  // A completion is only legal if something is, or is just becoming, outstanding.
  assign rsp_ok   = wr_rsp_valid && ((outstanding != '0) || issue);
  assign rsp_bad  = wr_rsp_valid && !rsp_ok;
  assign start_ok = start && (state != ST_RUN);

  assign in_flight   = outstanding + cnt_t'(buf_cnt) + cnt_t'(pop_pending);
  assign buf_room    = ({1'b0, buf_cnt} + {2'b00, pop_pending}) < 3'd2;
  assign rsp_cnt_nxt = rsp_cnt + CNT_WIDTH'(rsp_ok);

  assign fifo_re = !reset && (state == ST_RUN) && !fifo_empty && (pop_cnt < len) &&
                   buf_room && (in_flight < cnt_t'(MAX_OUTSTANDING));

  assign wr_req_valid = (buf_cnt != 2'd0);
  assign wr_req_addr  = base_addr + ADDR_WIDTH'(issue_cnt);

  wr_skid_buffer #(
    .W (CL_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (pop_pending),
    .push_data (fifo_dout),
    .pop       (issue),
    .head_data (wr_req_data),
    .count     (buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      len         <= '0;
      base_addr   <= '0;
      pop_cnt     <= '0;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
      pop_pending <= 1'b0;
      rsp_error   <= 1'b0;
    end else begin
      pop_pending <= fifo_re;
      if (start_ok) begin
        state       <= ST_RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        len         <= ctx_length;
        base_addr   <= dst_base_addr;
        pop_cnt     <= '0;
        issue_cnt   <= '0;
        rsp_cnt     <= '0;
        outstanding <= '0;
        rsp_error   <= 1'b0;
      end else begin
        if (fifo_re) begin
          pop_cnt <= pop_cnt + CNT_WIDTH'(1);
        end
        if (issue) begin
          issue_cnt <= issue_cnt + CNT_WIDTH'(1);
        end
        rsp_cnt <= rsp_cnt_nxt;
        if (issue && !rsp_ok) begin
          outstanding <= outstanding + cnt_t'(1);
        end else if (rsp_ok && !issue) begin
          outstanding <= outstanding - cnt_t'(1);
        end
        if (rsp_bad) begin
          rsp_error <= 1'b1;
        end
        if ((state == ST_RUN) && (rsp_cnt_nxt == len)) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_afu_write_stage.sv
// Scoreboard bench for afu_write_stage: a modelled output FIFO feeds the DUT,
// expected (addr,data) pairs are queued on load and checked at each accepted request.
module tb_afu_write_stage;
  import afu_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [31:0]         ctx_length;
  logic [31:0]         dst_base_addr;
  logic [CL_WIDTH-1:0] fifo_dout = '0;
  logic                fifo_empty;
  logic                fifo_re;
  logic                wr_req_valid;
  logic                wr_req_ready;
  logic [31:0]         wr_req_addr;
  logic [CL_WIDTH-1:0] wr_req_data;
  logic                wr_rsp_valid;
  logic                busy;
  logic                done;
  logic                rsp_error;

  always #5 clk = ~clk;

  afu_write_stage #(
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (8),
    .CNT_WIDTH       (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ctx_length    (ctx_length),
    .dst_base_addr (dst_base_addr),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_re       (fifo_re),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_rsp_valid  (wr_rsp_valid),
    .busy          (busy),
    .done          (done),
    .rsp_error     (rsp_error)
  );

  // Output FIFO model: data appears on fifo_dout the cycle after fifo_re.
  logic [CL_WIDTH-1:0] fifo_mem [0:255];
  int fifo_wr_idx = 0;
  int fifo_rd_idx = 0;
  assign fifo_empty = (fifo_rd_idx >= fifo_wr_idx);
  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_dout   <= fifo_mem[fifo_rd_idx];
      fifo_rd_idx <= fifo_rd_idx + 1;
    end
  end

  typedef struct packed {
    logic [31:0]         addr;
    logic [CL_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   rsp_due[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   re_cnt, issued, first_re, first_vld, done_cyc, last_rsp_cyc;
  int   line_id = 0;
  bit   auto_rsp;
  bit   inject_rsp;
  bit   ready_q;

  task automatic chk(input string tag, input logic [CL_WIDTH-1:0] obs, input logic [CL_WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_track();
    re_cnt = 0; issued = 0;
    first_re = -1; first_vld = -1; done_cyc = -1; last_rsp_cyc = -1;
  endtask

  // One cycle: drive inputs at negedge, then observe what the next posedge will do.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    wr_req_ready = ready_q;
    wr_rsp_valid = 1'b0;
    if (inject_rsp) begin
      wr_rsp_valid = 1'b1;
      inject_rsp   = 1'b0;
    end else if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
      void'(rsp_due.pop_front());
      wr_rsp_valid = 1'b1;
    end
    if (wr_rsp_valid) last_rsp_cyc = cyc;
    #1;
    if (done && done_cyc < 0) done_cyc = cyc;
    if (fifo_re) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
    end
    if (wr_req_valid && first_vld < 0) first_vld = cyc;
    if (wr_req_valid && wr_req_ready) begin
      issued++;
      chk("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("req_addr", wr_req_addr, e.addr);
        chk("req_data", wr_req_data, e.data);
      end
      if (auto_rsp) rsp_due.push_back(cyc + 3);
    end
  endtask

  task automatic load(input logic [31:0] base, input int n);
    logic [31:0]         tag;
    logic [CL_WIDTH-1:0] d;
    for (int i = 0; i < n; i++) begin
      tag = 32'hD000_0000 + 32'(line_id);
      line_id++;
      d = {16{tag}};
      fifo_mem[fifo_wr_idx] = d;
      fifo_wr_idx++;
      exp_q.push_back('{addr: base + 32'(i), data: d});
    end
  endtask

  task automatic pulse_start(input logic [31:0] len, input logic [31:0] base);
    ctx_length    = len;
    dst_base_addr = base;
    clear_track();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic flush_bench();
    fifo_wr_idx = fifo_rd_idx;
    exp_q.delete();
    rsp_due.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          stable;
    logic [31:0] hold_addr;
    logic [CL_WIDTH-1:0] hold_data;
    int          k;

    reset = 1'b1; start = 1'b0; ctx_length = '0; dst_base_addr = '0;
    wr_req_ready = 1'b1; wr_rsp_valid = 1'b0;
    ready_q = 1'b1; auto_rsp = 1'b1; inject_rsp = 1'b0;
    clear_track();
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fifo_re", fifo_re, 1'b0);
    chk("rst_valid", wr_req_valid, 1'b0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_addr", wr_req_addr, 32'h0);

    // Basic run: 4 lines from 0x100, completions 3 cycles after each issue.
    load(32'h100, 4);
    pulse_start(4, 32'h100);
    chk("t1_busy", busy, 1'b1);
    wait_done("t1_done", 100);
    chk("t1_latency", first_vld - first_re, 2);
    chk("t1_done_timing", done_cyc, last_rsp_cyc + 1);
    chk("t1_pops", re_cnt, 4);
    chk("t1_issued", issued, 4);
    chk("t1_sb_drained", exp_q.size(), 0);
    chk("t1_busy_low", busy, 1'b0);

    // Stray completion in DONE sets the sticky error.
    inject_rsp = 1'b1;
    step(); step();
    chk("stray_rsp_error", rsp_error, 1'b1);
    chk("stray_done_held", done, 1'b1);

    // Back-pressure: ready low for 10 cycles after the first valid.
    ready_q = 1'b0;
    load(32'h100, 6);
    pulse_start(6, 32'h100);
    chk("t2_rsp_error_clr", rsp_error, 1'b0);
    k = 0;
    while (!wr_req_valid && k < 20) begin step(); k++; end
    chk("t2_valid_seen", wr_req_valid, 1'b1);
    hold_addr = wr_req_addr;
    hold_data = wr_req_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_req_addr !== hold_addr || wr_req_data !== hold_data || !wr_req_valid) stable = 1'b0;
    end
    chk("t2_stable", stable, 1'b1);
    chk("t2_hold_addr", wr_req_addr, 32'h100);
    chk("t2_hold_data", wr_req_data, exp_q[0].data);
    chk("t2_pops_le2", re_cnt <= 2, 1'b1);
    ready_q = 1'b1;
    wait_done("t2_done", 200);
    chk("t2_issued", issued, 6);

    // Credit limit: 20 lines, no completions.
    auto_rsp = 1'b0;
    load(32'h500, 20);
    pulse_start(20, 32'h500);
    for (int i = 0; i < 40; i++) step();
    chk("t3_issued", issued, 8);
    chk("t3_pops", re_cnt, 8);
    chk("t3_fifo_re_low", fifo_re, 1'b0);
    chk("t3_valid_low", wr_req_valid, 1'b0);
    inject_rsp = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t3_issued_after_rsp", issued, 9);
    chk("t3_pops_after_rsp", re_cnt, 9);
    chk("t3_no_error", rsp_error, 1'b0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    flush_bench();
    step();
    auto_rsp = 1'b1;

    // Zero-length job.
    pulse_start(0, 32'h400);
    chk("t4_busy", busy, 1'b1);
    step();
    chk("t4_done", done, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("t4_no_pop", re_cnt, 0);
    chk("t4_no_req", issued, 0);
    chk("t4_never_valid", first_vld < 0, 1'b1);

    // Address wrap.
    load(32'hFFFF_FFFE, 4);
    pulse_start(4, 32'hFFFF_FFFE);
    wait_done("t5_done", 100);
    chk("t5_issued", issued, 4);

    // Reset mid-job, then a fresh job from a new base.
    load(32'h200, 8);
    pulse_start(8, 32'h200);
    k = 0;
    while (issued < 3 && k < 50) begin step(); k++; end
    chk("t6_three_issued", issued, 3);
    ready_q = 1'b0;
    step();
    rsp_due.delete();
    reset = 1'b1;
    step();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_fifo_re", fifo_re, 1'b0);
    chk("t6_rst_valid", wr_req_valid, 1'b0);
    chk("t6_rst_addr", wr_req_addr, 32'h0);
    chk("t6_rst_data", wr_req_data, '0);
    chk("t6_rst_error", rsp_error, 1'b0);
    reset = 1'b0;
    flush_bench();
    ready_q = 1'b1;
    step();
    load(32'h300, 2);
    pulse_start(2, 32'h300);
    wait_done("t6_done", 100);
    chk("t6_issued", issued, 2);
    chk("t6_pops", re_cnt, 2);
    chk("t6_no_error", rsp_error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
